conv_ddr3_arbiter: RTL and testbench

- Shares the single UniPHY DDR3 Avalon-MM port (avl_*) between two convolution-engine masters: m0 (feature/weight fetch) and m1 (result writeback/readback).
- Round-robin arbitration at burst granularity, with pipelined reads. Read data is routed back to the correct master through a tag FIFO.
- Holds both masters off until DDR3 calibration succeeds. Reports calibration failure and protocol errors to the NiosII/LED status path.

---
 rtl/conv_mem_pkg.sv | 32 +++
 rtl/conv_rd_tag_fifo.sv | 55 +++++
 rtl/conv_ddr3_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_conv_ddr3_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mem_pkg.sv
// Shared types for the convolution-engine DDR3 arbiter: default widths,
// arbiter states, master id and the read-return tag.
package conv_mem_pkg;

  localparam int ADDR_W_DEF  = 24;
  localparam int DATA_W_DEF  = 32;
  localparam int BURST_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_WAIT_CAL = 3'd0,
    ST_IDLE     = 3'd1,
    ST_GRANT_RD = 3'd2,
    ST_GRANT_WR = 3'd3,
    ST_FAIL     = 3'd4
  } arb_state_t;

  typedef logic mid_t;
  localparam mid_t MID_M0 = 1'b0;
  localparam mid_t MID_M1 = 1'b1;

  // One entry per outstanding read burst: who asked and how many beats return.
  typedef struct packed {
    mid_t                   id;
    logic [BURST_W_DEF-1:0] burstcount;
  } rd_tag_t;

  // A burstcount of zero still moves one beat.
  function automatic logic [BURST_W_DEF-1:0] burst_beats(input logic [BURST_W_DEF-1:0] bc);
    return (bc == '0) ? BURST_W_DEF'(1) : bc;
  endfunction

endpackage

// File: rtl/conv_rd_tag_fifo.sv
// Tag FIFO for outstanding read bursts. The head is read combinationally so
// the return path can steer readdatavalid with zero latency.
module conv_rd_tag_fifo
  import conv_mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk_clk,
  input  logic    reset_reset_n,
  input  logic    i_push,
  input  rd_tag_t i_push_data,
  input  logic    i_pop,
  output rd_tag_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  rd_tag_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/conv_ddr3_arbiter.sv
// Shares the UniPHY DDR3 Avalon-MM port between the fetch master (m0) and the
// writeback master (m1): burst-granular round robin, pipelined reads with
// tag-steered returns, gated on calibration. The tag width follows the package
// default, so BURST_W is expected to stay at BURST_W_DEF.
module conv_ddr3_arbiter
  import conv_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BURST_W    = BURST_W_DEF,
  parameter int PEND_DEPTH = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [BURST_W-1:0]  m0_burstcount,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [BURST_W-1:0]  m1_burstcount,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   avl_address,
  output logic                avl_read,
  output logic                avl_write,
  output logic [DATA_W-1:0]   avl_writedata,
  output logic [DATA_W/8-1:0] avl_byteenable,
  output logic [BURST_W-1:0]  avl_burstcount,
  input  logic                avl_waitrequest,
  input  logic [DATA_W-1:0]   avl_readdata,
  input  logic                avl_readdatavalid,
  input  logic                local_init_done,
  input  logic                local_cal_success,
  input  logic                local_cal_fail,
  output logic                mem_ready,
  output logic                mem_error
);

  arb_state_t          r_state, w_state_next;
  mid_t                r_grant, w_grant_next, r_last, w_last_next, w_pick;
  logic [BURST_W-1:0]  r_wr_cnt, w_wr_left, r_rd_cnt, w_rd_left;
  logic                r_wr_busy, r_rd_busy, r_mem_ready, r_mem_error;

  logic [ADDR_W-1:0]   w_m_address    [2];
  logic [DATA_W-1:0]   w_m_writedata  [2];
  logic [DATA_W/8-1:0] w_m_byteenable [2];
  logic [BURST_W-1:0]  w_m_burstcount [2];
  logic [1:0]          w_m_read, w_m_write, w_m_req, w_m_wait, w_m_rdv;

  logic                w_granted, w_rd_accept, w_wr_accept, w_wr_last;
  logic                w_pop, w_stray, w_fifo_full, w_fifo_empty, w_ready_next;
  rd_tag_t             w_push_tag, w_head;

  assign w_m_address    = '{m0_address, m1_address};
  assign w_m_writedata  = '{m0_writedata, m1_writedata};
  assign w_m_byteenable = '{m0_byteenable, m1_byteenable};
  assign w_m_burstcount = '{m0_burstcount, m1_burstcount};
  assign w_m_read       = {m1_read, m0_read};
  assign w_m_write      = {m1_write, m0_write};

  assign w_granted = (r_state == ST_GRANT_RD) || (r_state == ST_GRANT_WR);

  // Per-master eligibility, stall and routed read-valid.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign w_m_req[gi]  = w_m_write[gi] | (w_m_read[gi] & ~w_fifo_full);
      assign w_m_wait[gi] = (w_granted && (r_grant == mid_t'(gi))) ? avl_waitrequest : 1'b1;
      assign w_m_rdv[gi]  = avl_readdatavalid & ~w_fifo_empty & (w_head.id == mid_t'(gi));
    end
  endgenerate

  assign m0_waitrequest   = w_m_wait[0];
  assign m1_waitrequest   = w_m_wait[1];
  assign m0_readdatavalid = w_m_rdv[0];
  assign m1_readdatavalid = w_m_rdv[1];
  assign m0_readdata      = avl_readdata;
  assign m1_readdata      = avl_readdata;

  // The granted master drives the slave port straight through.
  assign avl_address    = w_m_address[r_grant];
  assign avl_writedata  = w_m_writedata[r_grant];
  assign avl_byteenable = w_m_byteenable[r_grant];
  assign avl_burstcount = w_m_burstcount[r_grant];
  assign avl_read       = (r_state == ST_GRANT_RD) & w_m_read[r_grant];
  assign avl_write      = (r_state == ST_GRANT_WR) & w_m_write[r_grant];

  assign w_rd_accept = avl_read & ~avl_waitrequest;
  assign w_wr_accept = avl_write & ~avl_waitrequest;
  assign w_wr_left   = r_wr_busy ? r_wr_cnt
                     : ((avl_burstcount == '0) ? BURST_W'(1) : avl_burstcount);
  assign w_wr_last   = w_wr_accept && (w_wr_left == BURST_W'(1));

  assign w_push_tag.id         = r_grant;
  assign w_push_tag.burstcount = BURST_W_DEF'(avl_burstcount);

  conv_rd_tag_fifo #(.DEPTH(PEND_DEPTH)) u_tag_fifo (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .i_push        (w_rd_accept),
    .i_push_data   (w_push_tag),
    .i_pop         (w_pop),
    .o_head        (w_head),
    .o_full        (w_fifo_full),
    .o_empty       (w_fifo_empty)
  );

  // Return path: remaining beats of the head burst; pop on its last beat.
  assign w_rd_left = r_rd_busy ? r_rd_cnt : BURST_W'(burst_beats(w_head.burstcount));
  assign w_pop     = avl_readdatavalid & ~w_fifo_empty & (w_rd_left == BURST_W'(1));
  assign w_stray   = avl_readdatavalid & w_fifo_empty;

  // Next-state and grant selection.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_last_next  = r_last;
    w_pick       = (&w_m_req) ? ~r_last : w_m_req[1];
    case (r_state)
      ST_WAIT_CAL: begin
        if (local_cal_fail)                            w_state_next = ST_FAIL;
        else if (local_init_done && local_cal_success) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!local_init_done) begin
          w_state_next = ST_WAIT_CAL;
        end else if (|w_m_req) begin
          w_grant_next = w_pick;
          w_state_next = w_m_write[w_pick] ? ST_GRANT_WR : ST_GRANT_RD;
        end
      end
      ST_GRANT_RD: begin
        if (w_rd_accept) begin
          w_last_next  = r_grant;
          w_state_next = ST_IDLE;
        end
      end
      ST_GRANT_WR: begin
        if (w_wr_last) begin
          w_last_next  = r_grant;
          w_state_next = ST_IDLE;
        end
      end
      ST_FAIL:  w_state_next = ST_FAIL;
      default:  w_state_next = ST_WAIT_CAL;
    endcase
  end

  assign w_ready_next = (w_state_next == ST_IDLE) || (w_state_next == ST_GRANT_RD) ||
                        (w_state_next == ST_GRANT_WR);

  // State, grant and round-robin pointer; pointer starts favouring m0.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= ST_WAIT_CAL;
      r_grant <= MID_M0;
      r_last  <= MID_M1;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_last  <= w_last_next;
    end
  end

  // Write beat counter: latched from the first accepted beat of the burst.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_wr_cnt  <= '0;
      r_wr_busy <= 1'b0;
    end else if (w_wr_accept) begin
      r_wr_busy <= ~w_wr_last;
      r_wr_cnt  <= w_wr_left - 1'b1;
    end
  end

  // Read beat counter for the burst at the FIFO head.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rd_cnt  <= '0;
      r_rd_busy <= 1'b0;
    end else if (avl_readdatavalid && !w_fifo_empty) begin
      r_rd_busy <= ~w_pop;
      r_rd_cnt  <= w_rd_left - 1'b1;
    end
  end

  // Status: ready tracks the operational states, error is sticky until reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_mem_ready <= 1'b0;
      r_mem_error <= 1'b0;
    end else begin
      r_mem_ready <= w_ready_next;
      if ((w_state_next == ST_FAIL) || w_stray) r_mem_error <= 1'b1;
    end
  end

  assign mem_ready = r_mem_ready;
  assign mem_error = r_mem_error;

endmodule

// File: tb/tb_conv_ddr3_arbiter.sv
// Directed bench for conv_ddr3_arbiter: inputs change 2 ns after the rising
// edge, outputs are sampled 1 ns later, well clear of the next edge.
module tb_conv_ddr3_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [23:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [2:0]  m0_burstcount, m1_burstcount;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [23:0] avl_address;
  logic        avl_read, avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic [2:0]  avl_burstcount;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;
  logic        local_init_done, local_cal_success, local_cal_fail;
  logic        mem_ready, mem_error;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  exp2;
  logic [31:0] exp_d;

  always #5 clk_clk = ~clk_clk;

  conv_ddr3_arbiter dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_burstcount(m1_burstcount),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable), .avl_burstcount(avl_burstcount),
    .avl_waitrequest(avl_waitrequest), .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid),
    .local_init_done(local_init_done), .local_cal_success(local_cal_success),
    .local_cal_fail(local_cal_fail), .mem_ready(mem_ready), .mem_error(mem_error)
  );

  task automatic step();
    @(posedge clk_clk);
    #2;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 4'hF; m0_burstcount = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 4'h3; m1_burstcount = '0;
    avl_waitrequest = 0; avl_readdata = '0; avl_readdatavalid = 0;
    local_init_done = 0; local_cal_success = 0; local_cal_fail = 0;
    #3;
    n_cmp++;
    if ({avl_read, avl_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, mem_ready, mem_error} !== 8'b0011_0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00110000",
               {avl_read, avl_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, mem_ready, mem_error});
    end
    step();
    reset_reset_n = 1'b1;
    step();
  endtask

  task automatic test_cal_gating();
    m0_read = 1; m0_address = 24'h000100; m0_burstcount = 3'd4;
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      n_cmp++;
      if ({m0_waitrequest, avl_read, mem_ready} !== 3'b100) begin
        n_bad++; $display("FAIL cal_gate_hold: got %b want 100", {m0_waitrequest, avl_read, mem_ready});
      end
    end
    step();
    local_init_done = 1; local_cal_success = 1;
    step(); #1;
    n_cmp++;
    if ({mem_ready, avl_read, m0_waitrequest} !== 3'b101) begin
      n_bad++; $display("FAIL cal_gate_idle: got %b want 101", {mem_ready, avl_read, m0_waitrequest});
    end
    step(); #1;
    n_cmp++;
    if ({avl_read, avl_address, avl_burstcount, m0_waitrequest, m1_waitrequest} !== {1'b1, 24'h000100, 3'd4, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL cal_gate_issue: got rd=%b a=%h bc=%0d w0=%b w1=%b want 1 000100 4 0 1",
                        avl_read, avl_address, avl_burstcount, m0_waitrequest, m1_waitrequest);
    end
    step();
    m0_read = 0;
    for (int b = 0; b < 4; b++) begin
      avl_readdatavalid = 1; avl_readdata = 32'h1000_0000 + 32'(b); #1;
      n_cmp++;
      if ({m0_readdatavalid, m1_readdatavalid, m0_readdata} !== {2'b10, avl_readdata}) begin
        n_bad++; $display("FAIL cal_gate_return beat %0d: got v=%b%b d=%h want 10 %h",
                          b, m0_readdatavalid, m1_readdatavalid, m0_readdata, avl_readdata);
      end
      step();
    end
    avl_readdatavalid = 0;
  endtask

  task automatic test_cal_fail();
    local_init_done = 0;
    step();
    local_init_done = 1; local_cal_fail = 1;
    step(); #1;
    n_cmp++;
    if ({mem_error, mem_ready} !== 2'b10) begin
      n_bad++; $display("FAIL cal_fail_enter: got err/rdy %b want 10", {mem_error, mem_ready});
    end
    local_cal_fail = 0; m0_read = 1; m1_write = 1; m1_burstcount = 3'd1;
    for (int c = 0; c < 100; c++) begin
      step(); #1;
      n_cmp++;
      if ({m0_waitrequest, m1_waitrequest, avl_read, avl_write, mem_error, mem_ready} !== 6'b110010) begin
        n_bad++; $display("FAIL cal_fail_stall cycle %0d: got %b want 110010", c,
                          {m0_waitrequest, m1_waitrequest, avl_read, avl_write, mem_error, mem_ready});
      end
    end
    m0_read = 0; m1_write = 0;
    reset_reset_n = 0; #1;
    n_cmp++;
    if ({mem_error, mem_ready} !== 2'b00) begin
      n_bad++; $display("FAIL cal_fail_reset: got err/rdy %b want 00", {mem_error, mem_ready});
    end
    step();
    reset_reset_n = 1;
    step(); #1;
    n_cmp++;
    if ({mem_ready, mem_error} !== 2'b10) begin
      n_bad++; $display("FAIL cal_fail_recover: got rdy/err %b want 10", {mem_ready, mem_error});
    end
    step();
  endtask

  task automatic test_contention();
    m0_read = 1; m0_address = 24'h000200; m0_burstcount = 3'd4;
    m1_read = 1; m1_address = 24'h000300; m1_burstcount = 3'd2;
    step(); #1;
    n_cmp++;
    if ({avl_read, avl_address, avl_burstcount, m0_waitrequest, m1_waitrequest} !== {1'b1, 24'h000200, 3'd4, 2'b01}) begin
      n_bad++; $display("FAIL contention_first: got rd=%b a=%h bc=%0d w=%b%b want 1 000200 4 01",
                        avl_read, avl_address, avl_burstcount, m0_waitrequest, m1_waitrequest);
    end
    step();
    m0_read = 0; #1;
    n_cmp++;
    if ({avl_read, m1_waitrequest} !== 2'b01) begin
      n_bad++; $display("FAIL contention_gap: got rd/w1 %b want 01", {avl_read, m1_waitrequest});
    end
    step(); #1;
    n_cmp++;
    if ({avl_read, avl_address, avl_burstcount, m0_waitrequest, m1_waitrequest} !== {1'b1, 24'h000300, 3'd2, 2'b10}) begin
      n_bad++; $display("FAIL contention_second: got rd=%b a=%h bc=%0d w=%b%b want 1 000300 2 10",
                        avl_read, avl_address, avl_burstcount, m0_waitrequest, m1_waitrequest);
    end
    step();
    m1_read = 0;
    for (int b = 0; b < 6; b++) begin
      avl_readdatavalid = 1; avl_readdata = 32'hC0DE_0000 + 32'(b); exp_d = 32'hC0DE_0000 + 32'(b); #1;
      exp2 = (b < 4) ? 2'b10 : 2'b01;
      n_cmp++;
      if ({m0_readdatavalid, m1_readdatavalid} !== exp2 || m1_readdata !== exp_d) begin
        n_bad++; $display("FAIL contention_return beat %0d: got v=%b%b d=%h want %b %h",
                          b + 1, m0_readdatavalid, m1_readdatavalid, m1_readdata, exp2, exp_d);
      end
      step();
    end
    avl_readdatavalid = 0;
  endtask

  task automatic test_write_burst();
    logic        wait_pat [5];
    logic [31:0] wdata    [4];
    int          beat;
    int          n_beats;
    wait_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    wdata    = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    beat = 0; n_beats = 0;
    m1_write = 1; m1_address = 24'h000400; m1_burstcount = 3'd4; m1_writedata = wdata[0];
    step();
    m0_read = 1; m0_address = 24'h000500; m0_burstcount = 3'd0;
    for (int c = 0; c < 5; c++) begin
      avl_waitrequest = wait_pat[c]; m1_writedata = wdata[beat]; #1;
      n_cmp++;
      if ({avl_write, avl_read, m0_waitrequest, m1_waitrequest, avl_writedata, avl_byteenable} !==
          {2'b10, 1'b1, wait_pat[c], wdata[beat], 4'h3}) begin
        n_bad++; $display("FAIL write_beat cycle %0d: got wr=%b rd=%b w=%b%b d=%h be=%h want 1 0 1%b %h 3",
                          c, avl_write, avl_read, m0_waitrequest, m1_waitrequest, avl_writedata, avl_byteenable,
                          wait_pat[c], wdata[beat]);
      end
      if (avl_write && !avl_waitrequest) n_beats++;
      step();
      if (!wait_pat[c]) beat++;
    end
    avl_waitrequest = 0; m1_write = 0; #1;
    n_cmp++;
    if (n_beats !== 4 || {avl_write, avl_read, m0_waitrequest} !== 3'b001) begin
      n_bad++; $display("FAIL write_done: got beats=%0d wr/rd/w0=%b want 4 001", n_beats, {avl_write, avl_read, m0_waitrequest});
    end
    step(); #1;
    n_cmp++;
    if ({avl_read, avl_address, m0_waitrequest} !== {1'b1, 24'h000500, 1'b0}) begin
      n_bad++; $display("FAIL write_then_read: got rd=%b a=%h w0=%b want 1 000500 0", avl_read, avl_address, m0_waitrequest);
    end
    step();
    m0_read = 0;
    avl_readdatavalid = 1; avl_readdata = 32'h5555_AAAA; #1;
    n_cmp++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin
      n_bad++; $display("FAIL zero_burst_return: got %b%b want 10", m0_readdatavalid, m1_readdatavalid);
    end
    step();
    avl_readdatavalid = 0;
  endtask

  task automatic test_fifo_full();
    m0_read = 1; m0_burstcount = 3'd1;
    for (int i = 0; i < 8; i++) begin
      m0_address = 24'h000600 + 24'(i);
      step(); #1;
      n_cmp++;
      if ({avl_read, m0_waitrequest} !== 2'b10) begin
        n_bad++; $display("FAIL fifo_fill read %0d: got rd/w0 %b want 10", i, {avl_read, m0_waitrequest});
      end
      step();
    end
    m0_address = 24'h000608;
    m1_write = 1; m1_address = 24'h000700; m1_burstcount = 3'd1; m1_writedata = 32'hFEED_BEEF;
    step(); #1;
    n_cmp++;
    if ({avl_read, avl_write, m0_waitrequest, m1_waitrequest} !== 4'b0110) begin
      n_bad++; $display("FAIL fifo_full_write: got %b want 0110", {avl_read, avl_write, m0_waitrequest, m1_waitrequest});
    end
    step();
    m1_write = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if ({avl_read, m0_waitrequest} !== 2'b01) begin
        n_bad++; $display("FAIL fifo_full_hold cycle %0d: got rd/w0 %b want 01", c, {avl_read, m0_waitrequest});
      end
      step();
    end
    avl_readdatavalid = 1; avl_readdata = 32'h0;
    step();
    avl_readdatavalid = 0; #1;
    n_cmp++;
    if (avl_read !== 1'b0) begin
      n_bad++; $display("FAIL fifo_pop_latency: got rd %b want 0", avl_read);
    end
    step(); #1;
    n_cmp++;
    if ({avl_read, avl_address, m0_waitrequest} !== {1'b1, 24'h000608, 1'b0}) begin
      n_bad++; $display("FAIL fifo_reissue: got rd=%b a=%h w0=%b want 1 000608 0", avl_read, avl_address, m0_waitrequest);
    end
    step();
    m0_read = 0;
    for (int b = 0; b < 5; b++) begin
      avl_readdatavalid = 1; avl_readdata = 32'h6000_0000 + 32'(b); #1;
      n_cmp++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin
        n_bad++; $display("FAIL fifo_drain beat %0d: got %b%b want 10", b, m0_readdatavalid, m1_readdatavalid);
      end
      step();
    end
    avl_readdatavalid = 0;
  endtask

  task automatic test_reset_mid_op();
    m1_write = 1; m1_address = 24'h000800; m1_burstcount = 3'd4; m1_writedata = 32'hB0B0_B0B0;
    step(); #1;
    n_cmp++;
    if ({avl_write, m1_waitrequest, avl_writedata} !== {2'b10, 32'hB0B0_B0B0}) begin
      n_bad++; $display("FAIL midop_beat1: got wr=%b w1=%b d=%h want 1 0 b0b0b0b0", avl_write, m1_waitrequest, avl_writedata);
    end
    step();
    m1_writedata = 32'hB1B1_B1B1;
    reset_reset_n = 0; avl_readdatavalid = 1; #1;
    n_cmp++;
    if ({avl_read, avl_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, mem_ready, mem_error} !== 8'b0011_0000) begin
      n_bad++; $display("FAIL midop_async_reset: got %b want 00110000",
                        {avl_read, avl_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, mem_ready, mem_error});
    end
    step();
    n_cmp++;
    if ({avl_read, avl_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, mem_ready, mem_error} !== 8'b0011_0000) begin
      n_bad++; $display("FAIL midop_reset_edge: got %b want 00110000",
                        {avl_read, avl_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, mem_ready, mem_error});
    end
    m1_write = 0; avl_readdatavalid = 0; reset_reset_n = 1;
    step(); #1;
    n_cmp++;
    if ({mem_ready, mem_error} !== 2'b10) begin
      n_bad++; $display("FAIL midop_restart: got rdy/err %b want 10", {mem_ready, mem_error});
    end
    avl_readdatavalid = 1; #1;
    n_cmp++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      n_bad++; $display("FAIL stray_routed: got %b%b want 00", m0_readdatavalid, m1_readdatavalid);
    end
    step();
    avl_readdatavalid = 0; #1;
    n_cmp++;
    if ({mem_error, mem_ready} !== 2'b11) begin
      n_bad++; $display("FAIL stray_error: got err/rdy %b want 11", {mem_error, mem_ready});
    end
  endtask

  initial begin
    test_reset();
    test_cal_gating();
    test_cal_fail();
    test_contention();
    test_write_burst();
    test_fifo_full();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
